// File: rtl/idct_stream_pingpong_wrapper.sv
// Ping-pong AXI-Stream front end for the HLS IDCT core's memory-master port (N x N words per bank).
// Define IDCT_OUT_SAT_EN to clamp results to the signed OUT_W range; otherwise results are truncated.
module idct_stream_pingpong_wrapper #(
    parameter int N      = 8,
    parameter int IN_W   = 12,
    parameter int OUT_W  = 9,
    parameter int CORE_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N*IN_W-1:0]    s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [N*OUT_W-1:0]   m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic                 core_start,
    input  logic                 core_done,
    input  logic                 core_oe,
    input  logic                 core_we,
    input  logic [31:0]          core_addr,
    input  logic [CORE_W-1:0]    core_wdata,
    input  logic [4:0]           core_size,
    output logic [CORE_W-1:0]    core_rdata,
    output logic                 core_rdy,
    output logic                 err
);
    localparam int WORDS = N * N;
    localparam int AW    = $clog2(WORDS);
    localparam int RW    = $clog2(N);
    localparam int BYTES = CORE_W / 8;

    typedef enum logic [2:0] {B_EMPTY, B_FILLING, B_READY, B_RUN, B_DONE} bank_state_t;
    typedef enum logic [1:0] {C_IDLE, C_START, C_RUN} cmp_state_t;

    logic [CORE_W-1:0] mem [2][WORDS];
    bank_state_t       bank_state [2];
    cmp_state_t        cmp_state;
    logic              wr_sel, cmp_sel, rd_sel;
    logic [RW-1:0]     in_row, out_row;

    logic              in_fire, out_fire, strobe, in_range, core_rd, core_wr;
    logic [31:0]       word_full;
    logic [AW-1:0]     word;
    logic [CORE_W-1:0] mask;
    logic              next_sel, next_load;
    logic [RW-1:0]     next_row;

    function automatic logic [OUT_W-1:0] to_out(input logic [CORE_W-1:0] w);
`ifdef IDCT_OUT_SAT_EN
        logic signed [CORE_W-1:0] s, hi, lo;
        s  = signed'(w);
        hi = CORE_W'((1 << (OUT_W - 1)) - 1);
        lo = ~hi;
        if (s > hi) return hi[OUT_W-1:0];
        if (s < lo) return lo[OUT_W-1:0];
        return w[OUT_W-1:0];
`else
        return w[OUT_W-1:0];
`endif
    endfunction

    assign s_tready  = (bank_state[wr_sel] == B_EMPTY) || (bank_state[wr_sel] == B_FILLING);
    assign in_fire   = s_tvalid && s_tready;
    assign out_fire  = m_tvalid && m_tready;
    assign strobe    = core_oe || core_we;
    assign core_rdy  = strobe;
    assign word_full = core_addr / 32'(BYTES);
    assign word      = word_full[AW-1:0];
    assign in_range  = word_full < 32'(WORDS);
    assign core_rd   = (cmp_state == C_RUN) && core_oe && !core_we && in_range;
    assign core_wr   = (cmp_state == C_RUN) && core_we && !core_oe && in_range;

    // core_size of 0 or at least the word width means a full-word access
    always_comb begin
        mask = '1;
        if (core_size != 5'd0 && 32'(core_size) < 32'(CORE_W))
            mask = (CORE_W'(1) << core_size) - CORE_W'(1);
    end

    assign core_rdata = core_rd ? (mem[cmp_sel][word] & mask) : '0;

    // Which bank/row the output register loads next; the hand-off to the other bank costs no bubble.
    always_comb begin
        next_sel  = rd_sel;
        next_row  = out_row;
        next_load = 1'b0;
        if (out_fire) begin
            if (out_row == RW'(N - 1)) begin
                next_sel  = ~rd_sel;
                next_row  = '0;
                next_load = (bank_state[~rd_sel] == B_DONE);
            end else begin
                next_row  = out_row + 1'b1;
                next_load = 1'b1;
            end
        end else if (!m_tvalid) begin
            next_load = (bank_state[rd_sel] == B_DONE);
        end
    end

    always_ff @(posedge clock) begin
        if (in_fire)
            for (int k = 0; k < N; k++)
                mem[wr_sel][AW'(in_row * N + k)] <=
                    {{(CORE_W - IN_W){s_tdata[k*IN_W + IN_W - 1]}}, s_tdata[k*IN_W +: IN_W]};
        if (core_wr)
            mem[cmp_sel][word] <= core_wdata & mask;
    end

    // The core's own active-low reset is ~reset, wired at the level that instantiates both blocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            bank_state[0] <= B_EMPTY;
            bank_state[1] <= B_EMPTY;
            cmp_state     <= C_IDLE;
            wr_sel        <= 1'b0;
            cmp_sel       <= 1'b0;
            rd_sel        <= 1'b0;
            in_row        <= '0;
            out_row       <= '0;
            core_start    <= 1'b0;
            m_tvalid      <= 1'b0;
            m_tlast       <= 1'b0;
            m_tdata       <= '0;
            err           <= 1'b0;
        end else begin
            if (in_fire) begin
                if (s_tlast != (in_row == RW'(N - 1))) err <= 1'b1;
                if (in_row == RW'(N - 1)) begin
                    bank_state[wr_sel] <= B_READY;
                    wr_sel             <= ~wr_sel;
                    in_row             <= '0;
                end else begin
                    bank_state[wr_sel] <= B_FILLING;
                    in_row             <= in_row + 1'b1;
                end
            end

            core_start <= 1'b0;
            case (cmp_state)
                C_IDLE: if (bank_state[cmp_sel] == B_READY) begin
                    cmp_state  <= C_START;
                    core_start <= 1'b1;
                end
                C_START: begin
                    bank_state[cmp_sel] <= B_RUN;
                    cmp_state           <= C_RUN;
                end
                C_RUN: if (core_done) begin
                    bank_state[cmp_sel] <= B_DONE;
                    cmp_sel             <= ~cmp_sel;
                    cmp_state           <= C_IDLE;
                end
                default: cmp_state <= C_IDLE;
            endcase
            if (strobe && (cmp_state != C_RUN || !in_range)) err <= 1'b1;

            if (out_fire && out_row == RW'(N - 1)) bank_state[rd_sel] <= B_EMPTY;
            if (!m_tvalid || m_tready) begin
                m_tvalid <= next_load;
                m_tlast  <= next_load && (next_row == RW'(N - 1));
                if (next_load)
                    for (int k = 0; k < N; k++)
                        m_tdata[k*OUT_W +: OUT_W] <= to_out(mem[next_sel][AW'(next_row * N + k)]);
            end
            rd_sel  <= next_sel;
            out_row <= next_row;
        end
    end
endmodule

// File: tb/tb_idct_stream_pingpong_wrapper.sv
// Scoreboard bench for idct_stream_pingpong_wrapper with a behavioural core model driving the memory port.
// Expected rows come from array arithmetic on the issued coefficients; a monitor pops them per output beat.
module tb_idct_stream_pingpong_wrapper;
    localparam int N      = 8;
    localparam int IN_W   = 12;
    localparam int OUT_W  = 9;
    localparam int CORE_W = 16;
    localparam int W      = N * OUT_W + 1;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [N*IN_W-1:0]   s_tdata = '0;
    logic                s_tvalid = 1'b0;
    logic                s_tlast = 1'b0;
    logic                s_tready;
    logic [N*OUT_W-1:0]  m_tdata;
    logic                m_tvalid, m_tlast;
    logic                m_tready = 1'b1;
    logic                core_start;
    logic                core_done = 1'b0;
    logic                core_oe = 1'b0;
    logic                core_we = 1'b0;
    logic [31:0]         core_addr = '0;
    logic [CORE_W-1:0]   core_wdata = '0;
    logic [4:0]          core_size = '0;
    logic [CORE_W-1:0]   core_rdata;
    logic                core_rdy;
    logic                err;

    idct_stream_pingpong_wrapper #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .CORE_W(CORE_W)) dut (
        .clock(clock), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .core_start(core_start), .core_done(core_done), .core_oe(core_oe), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_size(core_size),
        .core_rdata(core_rdata), .core_rdy(core_rdy), .err(err)
    );

    // clock / reset
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [W-1:0] exp_q[$];
    int mode_q[$], delay_q[$], tlast_cyc[$];
    int starts = 0, blocks_sent = 0;
    int last_acc_cyc = 0, start_cyc = 0, done_cyc = 0, first_valid_cyc = 0;
    int ready_mode = 0;
    bit core_busy = 1'b0;
    logic [IN_W-1:0] coef [N*N];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // output conversion as the spec states it: clamp (saturation build) or keep the low bits
    function automatic logic [OUT_W-1:0] conv(input logic [CORE_W-1:0] v);
`ifdef IDCT_OUT_SAT_EN
        int sv;
        sv = int'($signed(v));
        if (sv > 255) return 9'h0FF;
        if (sv < -256) return 9'h100;
`endif
        return v[OUT_W-1:0];
    endfunction

    task automatic push_expected(input int mode);
        logic [CORE_W-1:0] w [N*N];
        logic [W-1:0] row;
        for (int i = 0; i < N*N; i++)
            w[i] = {{(CORE_W-IN_W){coef[i][IN_W-1]}}, coef[i]} + 16'd1;
        if (mode == 1) w[0] = 16'h0150;
        if (mode == 2) w[0] = 16'hFE00;
        if (mode == 4) w[1] = 16'h00CD;
        for (int r = 0; r < N; r++) begin
            row = '0;
            row[W-1] = (r == N - 1);
            for (int k = 0; k < N; k++) row[k*OUT_W +: OUT_W] = conv(w[r*N + k]);
            exp_q.push_back(row);
        end
    endtask

    task automatic fill_const(input logic [IN_W-1:0] v);
        for (int i = 0; i < N*N; i++) coef[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N*N; i++) begin
            case ($urandom_range(0, 7))
                0: coef[i] = 12'h800;
                1: coef[i] = 12'h7FF;
                default: coef[i] = IN_W'($urandom);
            endcase
        end
    endtask

    // input driver: enters and leaves on the posedge+1 phase
    task automatic send_block(input int mode, input int delay, input int tlast_row, input bit expect_out,
                              output int stalls, output int first_acc);
        int budget;
        if (expect_out) push_expected(mode);
        mode_q.push_back(mode);
        delay_q.push_back(delay);
        blocks_sent++;
        stalls = 0;
        first_acc = -1;
        for (int r = 0; r < N; r++) begin
            s_tvalid = 1'b1;
            s_tlast  = (r == tlast_row);
            for (int k = 0; k < N; k++) s_tdata[k*IN_W +: IN_W] = coef[r*N + k];
            budget = 0;
            @(negedge clock);
            while (!s_tready && budget < 3000) begin
                stalls++;
                budget++;
                @(negedge clock);
            end
            if (!s_tready) begin
                checks++;
                errors++;
                $display("FAIL in_accept: row %0d not accepted after %0d cycles", r, budget);
            end
            if (r == 0) first_acc = cyc;
            if (r == N - 1) last_acc_cyc = cyc;
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 0;
        while ((exp_q.size() != 0 || mode_q.size() != 0 || core_busy || m_tvalid) && budget < 5000) begin
            tick();
            budget++;
        end
        if (budget >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d rows still expected", exp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clock);
        check({tag, "_s_tready"}, s_tready, 1);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tlast"}, m_tlast, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_err"}, err, 0);
        tick();
    endtask

    // behavioural core: reads every word, writes it back +1, then a mode-specific extra write
    task automatic core_step(output bit ab);
        @(posedge clock);
        #2;
        ab = reset;
        if (reset) begin
            core_oe = 1'b0;
            core_we = 1'b0;
            core_done = 1'b0;
        end
    endtask

    task automatic core_write(input logic [31:0] a, input logic [15:0] d, input logic [4:0] sz, output bit ab);
        core_step(ab);
        if (ab) return;
        core_we = 1'b1;
        core_addr = a;
        core_wdata = d;
        core_size = sz;
        core_step(ab);
        core_we = 1'b0;
    endtask

    task automatic run_core();
        int mode = 0, delay = 0;
        bit ab;
        logic [CORE_W-1:0] rv;
        if (mode_q.size() != 0) mode = mode_q.pop_front();
        if (delay_q.size() != 0) delay = delay_q.pop_front();
        for (int i = 0; i < N*N; i++) begin
            core_step(ab);
            if (ab) return;
            core_we = 1'b0;
            core_oe = 1'b1;
            core_addr = 32'(i * 2);
            core_size = ($urandom_range(0, 1) == 1) ? 5'd16 : 5'd0;
            @(negedge clock);
            rv = core_rdata;
            core_step(ab);
            if (ab) return;
            core_oe = 1'b0;
            core_we = 1'b1;
            core_wdata = rv + 16'd1;
            core_size = 5'd16;
        end
        core_step(ab);
        if (ab) return;
        core_we = 1'b0;
        case (mode)
            1: core_write(32'h0, 16'h0150, 5'd16, ab);
            2: core_write(32'h0, 16'hFE00, 5'd16, ab);
            3: core_write(32'h80, 16'h1234, 5'd16, ab);
            4: core_write(32'h2, 16'hABCD, 5'd8, ab);
            default: ab = 1'b0;
        endcase
        if (ab) return;
        for (int d = 0; d < delay; d++) begin
            core_step(ab);
            if (ab) return;
        end
        core_step(ab);
        if (ab) return;
        core_done = 1'b1;
        core_step(ab);
        core_done = 1'b0;
    endtask

    initial forever begin
        @(negedge clock);
        if (!reset && core_start) begin
            core_busy = 1'b1;
            run_core();
            core_busy = 1'b0;
        end
    end

    initial forever begin
        @(posedge clock);
        #1;
        case (ready_mode)
            0: m_tready = 1'b1;
            1: m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b0;
        endcase
    end

    // monitor / scoreboard
    bit prev_start = 1'b0, prev_valid = 1'b0, hold_pend = 1'b0;
    logic [N*OUT_W-1:0] hold_data = '0;
    initial forever begin
        logic [W-1:0] e;
        @(negedge clock);
        if (reset) begin
            hold_pend = 1'b0;
            prev_start = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", m_tdata, hold_data);
            end
            if (core_start) begin
                starts++;
                start_cyc = cyc;
                check("start_single_cycle", prev_start, 0);
            end
            if (core_done) done_cyc = cyc;
            if (m_tvalid && !prev_valid) first_valid_cyc = cyc;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: data %0h with empty queue", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("row_data", m_tdata, e[W-2:0]);
                    check("row_last", m_tlast, e[W-1]);
                    if (m_tlast) tlast_cyc.push_back(cyc);
                end
            end
            hold_pend = m_tvalid && !m_tready;
            hold_data = m_tdata;
            prev_start = core_start;
            prev_valid = m_tvalid;
        end
    end

    initial begin
        int st, fa, st_b, fa_b, st_c, fa_c, a_idx, budget, s0;
        logic [N*OUT_W-1:0] held;

        do_reset();
        repeat (5) tick();
        check_reset_outputs("reset");

        // single block, constant input, observe both latencies
        fill_const(12'h005);
        send_block(0, 10, N - 1, 1'b1, st, fa);
        wait_drain();
        check("start_latency", start_cyc - last_acc_cyc, 2);
        check("out_latency", first_valid_cyc - done_cyc, 2);
        check("one_start_pulse", starts, 1);

        // two blocks back-to-back with a slow core, then a third that must wait for a free bank
        a_idx = tlast_cyc.size();
        fill_random();
        send_block(0, 70, N - 1, 1'b1, st, fa);
        fill_random();
        send_block(0, 70, N - 1, 1'b1, st_b, fa_b);
        check("no_stall_two_blocks", st + st_b, 0);
        fill_random();
        send_block(0, 10, N - 1, 1'b1, st_c, fa_c);
        check("third_block_stalled", st_c > 0, 1);
        if (tlast_cyc.size() > a_idx) check("third_after_block0_drain", fa_c > tlast_cyc[a_idx], 1);
        else begin
            checks++;
            errors++;
            $display("FAIL third_after_block0_drain: block 0 never completed before third block");
        end
        wait_drain();

        // back-pressure: hold for 10 cycles, then 8 consecutive beats
        ready_mode = 2;
        tick();
        fill_random();
        send_block(0, 5, N - 1, 1'b1, st, fa);
        budget = 0;
        @(negedge clock);
        while (!m_tvalid && budget < 2000) begin
            budget++;
            @(negedge clock);
        end
        held = m_tdata;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("stall_valid", m_tvalid, 1);
            check("stall_data", m_tdata, held);
        end
        ready_mode = 0;
        @(posedge clock);
        #2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("burst_beat", m_tvalid && m_tready, 1);
        end
        tick();
        wait_drain();

        // saturation / truncation corner words and a narrow write
        fill_random();
        send_block(1, 3, N - 1, 1'b1, st, fa);
        fill_random();
        send_block(2, 3, N - 1, 1'b1, st, fa);
        fill_random();
        send_block(4, 3, N - 1, 1'b1, st, fa);
        wait_drain();

        // randomized traffic with random back-pressure
        ready_mode = 1;
        for (int b = 0; b < 6; b++) begin
            int m;
            m = $urandom_range(0, 3);
            if (m == 3) m = 4;
            fill_random();
            send_block(m, $urandom_range(0, 40), N - 1, 1'b1, st, fa);
        end
        wait_drain();
        ready_mode = 0;
        tick();
        @(negedge clock);
        check("err_clean_traffic", err, 0);
        tick();

        // out-of-range core write
        fill_random();
        send_block(3, 3, N - 1, 1'b1, st, fa);
        wait_drain();
        @(negedge clock);
        check("err_bad_addr", err, 1);
        tick();
        do_reset();
        @(negedge clock);
        check("err_cleared_by_reset", err, 0);
        tick();

        // misplaced s_tlast still completes the block on row count
        fill_random();
        send_block(0, 3, 3, 1'b1, st, fa);
        wait_drain();
        @(negedge clock);
        check("err_tlast", err, 1);
        tick();
        do_reset();

        // reset while the core is running, then a normal block
        s0 = starts;
        fill_random();
        send_block(0, 300, N - 1, 1'b0, st, fa);
        budget = 0;
        while (starts == s0 && budget < 500) begin
            tick();
            budget++;
        end
        check("run_started", starts, s0 + 1);
        repeat (20) tick();
        do_reset();
        check_reset_outputs("mid_run_reset");
        fill_random();
        send_block(0, 5, N - 1, 1'b1, st, fa);
        wait_drain();
        @(negedge clock);
        check("err_after_recovery", err, 0);
        check("queue_empty", exp_q.size(), 0);
        check("start_count", starts, blocks_sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
